stage_1: RTL and testbench

STAGE_1 -- requirements
Module: stage_1

---
 rtl/stage_1_pkg.sv | 19 +
 rtl/stage_1_if_id_reg.sv | 37 +++
 rtl/stage_1.sv | 114 +++++++++++
 tb/tb_stage_1.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage_1_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_1_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_1_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise a bubble.
module if_id_reg
  import stage_1_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] next_inst,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst  <= NOP_INST;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= next_inst;
      pc    <= next_pc;
      valid <= 1'b1;
    end else if (!hold) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_1.sv
// Instruction fetch stage: single-outstanding memory requests, stall skid buffer,
// and redirect handling that drops a response still in flight.
module stage_1
  import stage_1_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_b_taken,
  input  logic [XLEN-1:0] i_b_pc,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_data,
  output logic [XLEN-1:0] if_id_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid
);

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_inst;
  logic [XLEN-1:0] hold_pc;

  logic            load;
  logic            hold;
  logic            use_buf;
  logic            pc_inc;
  logic            capture;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_REQ;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_REQ: begin
        if (i_b_taken)      next_state = i_mem_ack ? ST_REQ : ST_DROP;
        else if (i_mem_ack) next_state = i_stall ? ST_HOLD : ST_REQ;
      end
      ST_HOLD: begin
        if (i_b_taken || !i_stall) next_state = ST_REQ;
      end
      ST_DROP: begin
        if (!i_b_taken && i_mem_ack) next_state = ST_REQ;
      end
      default: next_state = ST_REQ;
    endcase
  end

  // Memory handshake and datapath strobes; a redirect overrides everything else.
  always_comb begin
    o_mem_req  = (state != ST_HOLD);
    o_mem_addr = pc;
    load       = 1'b0;
    hold       = i_stall;
    use_buf    = 1'b0;
    pc_inc     = 1'b0;
    capture    = 1'b0;
    if (!i_b_taken) begin
      case (state)
        ST_REQ: begin
          if (i_mem_ack) begin
            pc_inc  = 1'b1;
            capture = i_stall;
            load    = !i_stall;
          end
        end
        ST_HOLD: begin
          load    = !i_stall;
          use_buf = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          pc <= align_pc(RESET_PC);
    else if (i_b_taken) pc <= align_pc(i_b_pc);
    else if (pc_inc)    pc <= pc + XLEN'(4);
  end

  // Skid buffer for a word that arrives while decode is stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_b_taken) begin
      hold_inst <= '0;
      hold_pc   <= '0;
    end else if (capture) begin
      hold_inst <= i_mem_data;
      hold_pc   <= pc;
    end
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (load),
    .flush     (i_b_taken),
    .hold      (hold),
    .next_inst (use_buf ? hold_inst : i_mem_data),
    .next_pc   (use_buf ? hold_pc : pc),
    .inst      (if_id_inst),
    .pc        (if_id_pc),
    .valid     (if_id_valid)
  );

endmodule

// File: tb/tb_stage_1.sv
// Self-checking bench for stage_1: directed scenarios plus a randomized run
// checked against a sequential-fetch program model.
module tb_stage_1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        b_taken;
  logic [31:0] b_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;

  always #5 clk = ~clk;

  stage_1 dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stall     (stall),
    .i_b_taken   (b_taken),
    .i_b_pc      (b_pc),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_ack   (mem_ack),
    .i_mem_data  (mem_data),
    .if_id_inst  (if_id_inst),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Memory: zero-wait when lat==0, otherwise latches the address and acks lat cycles later.
  logic        busy;
  logic [1:0]  cnt;
  logic [31:0] maddr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= 2'd0;
      maddr <= 32'h0;
    end else if (busy) begin
      if (cnt == 2'd1) busy <= 1'b0;
      else             cnt  <= cnt - 2'd1;
    end else if (mem_req && lat != 0) begin
      busy  <= 1'b1;
      cnt   <= 2'(lat);
      maddr <= mem_addr;
    end
  end
  assign mem_ack  = busy ? (cnt == 2'd1) : (lat == 0 && mem_req);
  assign mem_data = word(busy ? maddr : mem_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; b_taken = 1'b0; b_pc = 32'h0; lat = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", if_id_valid); else n_pass++;
    n_checks++; if (if_id_inst !== NOP) $display("FAIL reset_inst got %h want %h", if_id_inst, NOP); else n_pass++;
    n_checks++; if (if_id_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", if_id_pc); else n_pass++;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL reset_req got req=%0b addr=%h want 1/0", mem_req, mem_addr); else n_pass++;
  endtask

  task automatic test_zero_wait();
    rst = 1'b0;
    cyc();
    n_checks++; if (if_id_pc !== 32'h0 || if_id_inst !== 32'h0050_0093 || if_id_valid !== 1'b1)
      $display("FAIL zw_first got pc=%h inst=%h v=%0b want 0/00500093/1", if_id_pc, if_id_inst, if_id_valid); else n_pass++;
    n_checks++; if (mem_addr !== 32'h4) $display("FAIL zw_next_addr got %h want 4", mem_addr); else n_pass++;
    cyc();
    n_checks++; if (if_id_pc !== 32'h4 || if_id_inst !== word(32'h4) || mem_addr !== 32'h8)
      $display("FAIL zw_second got pc=%h inst=%h addr=%h", if_id_pc, if_id_inst, mem_addr); else n_pass++;
  endtask

  task automatic test_latency();
    lat = 2;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) $display("FAIL lat_addr_hold got req=%0b addr=%h want 1/8", mem_req, mem_addr); else n_pass++;
      n_checks++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) $display("FAIL lat_bubble got v=%0b inst=%h want 0/%h", if_id_valid, if_id_inst, NOP); else n_pass++;
    end
    lat = 0;
    cyc();
    n_checks++; if (if_id_pc !== 32'h8 || if_id_valid !== 1'b1 || if_id_inst !== word(32'h8) || mem_addr !== 32'hC)
      $display("FAIL lat_deliver got pc=%h v=%0b inst=%h addr=%h", if_id_pc, if_id_valid, if_id_inst, mem_addr); else n_pass++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++; if (if_id_pc !== 32'h8 || if_id_valid !== 1'b1 || if_id_inst !== word(32'h8))
        $display("FAIL stall_frozen got pc=%h v=%0b inst=%h want 8/1", if_id_pc, if_id_valid, if_id_inst); else n_pass++;
      n_checks++; if (mem_req !== 1'b0) $display("FAIL stall_no_req got %0b want 0", mem_req); else n_pass++;
    end
    stall = 1'b0;
    cyc();
    n_checks++; if (if_id_pc !== 32'hC || if_id_valid !== 1'b1 || if_id_inst !== word(32'hC))
      $display("FAIL stall_release got pc=%h v=%0b inst=%h want c/1", if_id_pc, if_id_valid, if_id_inst); else n_pass++;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) $display("FAIL stall_next_fetch got req=%0b addr=%h want 1/10", mem_req, mem_addr); else n_pass++;
    cyc();
    n_checks++; if (if_id_pc !== 32'h10 || if_id_inst !== word(32'h10) || mem_addr !== 32'h14)
      $display("FAIL stall_no_dup got pc=%h inst=%h addr=%h want 10/-/14", if_id_pc, if_id_inst, mem_addr); else n_pass++;
  endtask

  task automatic test_redirect();
    repeat (3) cyc();
    n_checks++; if (mem_addr !== 32'h20) $display("FAIL redir_setup got %h want 20", mem_addr); else n_pass++;
    lat = 3;
    cyc();
    b_taken = 1'b1; b_pc = 32'h103;
    cyc();
    b_taken = 1'b0;
    n_checks++; if (mem_addr !== 32'h100 || if_id_valid !== 1'b0 || if_id_inst !== NOP)
      $display("FAIL redir_flush got addr=%h v=%0b inst=%h", mem_addr, if_id_valid, if_id_inst); else n_pass++;
    cyc();
    lat = 0;
    cyc();
    n_checks++; if (if_id_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100)
      $display("FAIL redir_drop got v=%0b req=%0b addr=%h want 0/1/100", if_id_valid, mem_req, mem_addr); else n_pass++;
    cyc();
    n_checks++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || if_id_inst !== word(32'h100) || mem_addr !== 32'h104)
      $display("FAIL redir_target got pc=%h v=%0b inst=%h addr=%h", if_id_pc, if_id_valid, if_id_inst, mem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    b_taken = 1'b1; b_pc = 32'hFFFF_FFFF;
    cyc();
    b_taken = 1'b0;
    n_checks++; if (mem_addr !== 32'hFFFF_FFFC || if_id_valid !== 1'b0)
      $display("FAIL wrap_setup got addr=%h v=%0b", mem_addr, if_id_valid); else n_pass++;
    cyc();
    n_checks++; if (mem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1)
      $display("FAIL wrap_next got addr=%h pc=%h v=%0b want 0/fffffffc/1", mem_addr, if_id_pc, if_id_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    b_taken = 1'b1; b_pc = 32'h40;
    cyc();
    b_taken = 1'b0; lat = 3;
    cyc();
    n_checks++; if (mem_addr !== 32'h40 || mem_req !== 1'b1) $display("FAIL rstmid_setup got addr=%h want 40", mem_addr); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h0 || mem_addr !== 32'h0 || mem_req !== 1'b1)
      $display("FAIL rstmid_async got v=%0b inst=%h pc=%h addr=%h req=%0b", if_id_valid, if_id_inst, if_id_pc, mem_addr, mem_req); else n_pass++;
    cyc();
    rst = 1'b0; lat = 0;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL rstmid_first_req got %h want 0", mem_addr); else n_pass++;
    cyc();
    n_checks++; if (if_id_pc !== 32'h0 || if_id_inst !== 32'h0050_0093 || if_id_valid !== 1'b1)
      $display("FAIL rstmid_first_inst got pc=%h inst=%h v=%0b", if_id_pc, if_id_inst, if_id_valid); else n_pass++;
  endtask

  // Program-order model: decode consumes IF/ID on unstalled, non-redirect cycles and
  // must see consecutive words from the last redirect target.
  task automatic test_random();
    logic [31:0] ep       = 32'h0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          consumed = 0;
    int          idle     = 0;
    rst = 1'b1; stall = 1'b0; b_taken = 1'b0; lat = 0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      lat     = (i / 300) % 4;
      stall   = ($urandom % 4) == 0;
      b_taken = ($urandom % 12) == 0;
      b_pc    = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      #1;
      if (prev_wait) begin
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== prev_addr)
          $display("FAIL rnd_addr_stable got req=%0b addr=%h want 1/%h", mem_req, mem_addr, prev_addr); else n_pass++;
      end
      n_checks++; if (mem_addr[1:0] !== 2'b00) $display("FAIL rnd_align got %h", mem_addr); else n_pass++;
      if (!stall && !b_taken && if_id_valid === 1'b1) begin
        n_checks++; if (if_id_pc !== ep || if_id_inst !== word(ep))
          $display("FAIL rnd_stream got pc=%h inst=%h want pc=%h inst=%h", if_id_pc, if_id_inst, ep, word(ep)); else n_pass++;
        ep = ep + 32'd4;
        consumed++;
        idle = 0;
      end else begin
        if (if_id_valid === 1'b0) begin
          n_checks++; if (if_id_inst !== NOP) $display("FAIL rnd_bubble_inst got %h want %h", if_id_inst, NOP); else n_pass++;
        end
        idle++;
      end
      if (b_taken) ep = {b_pc[31:2], 2'b00};
      prev_wait = mem_req && !mem_ack && !b_taken;
      prev_addr = mem_addr;
      if (idle > 60) begin
        n_checks++;
        $display("FAIL rnd_progress got %0d idle cycles want <= 60", idle);
        break;
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0; b_taken = 1'b0;
    n_checks++; if (consumed < 300) $display("FAIL rnd_throughput got %0d want >= 300", consumed); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
